// File: rtl/map_scroll_buffer.sv
// Map scroll window: captures one map row per scroll tick from the active
// RAM bank, shifts it into a DEPTH-row window seen by the renderer, and
// hands the row falling off the far end to the hit judge.
module map_scroll_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     map,
  input  logic [WIDTH-1:0]         ram1_read,
  input  logic [WIDTH-1:0]         ram2_read,
  input  logic                     ram1_read_en,
  input  logic                     ram2_read_en,
  input  logic                     scroll_tick,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [WIDTH-1:0]         rd_row,
  output logic [WIDTH-1:0]         out_row,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     full,
  output logic                     overrun,
  output logic                     tick_miss
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, SHIFT} state_t;

  state_t           state;
  logic             bank_one;
  logic             pending;
  logic [WIDTH-1:0] cap_reg;
  logic [WIDTH-1:0] window [DEPTH];
  logic [CW-1:0]    row_count;

  // A shift only commits while map mode is still on; dropping map parks everything.
  logic do_shift;
  assign do_shift = map && (state == SHIFT);

  assign full   = (row_count == CW'(DEPTH));
  assign rd_row = window[rd_idx];

  // Sequencer: wait for a tick, pick the bank that strobes, grab its data, then shift.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      bank_one  <= 1'b0;
      pending   <= 1'b0;
      cap_reg   <= '0;
      tick_miss <= 1'b0;
    end else if (!map) begin
      state   <= IDLE;
      pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (scroll_tick || pending) begin
            state   <= ARM;
            pending <= 1'b0;
          end
        end
        ARM: begin
          if (ram1_read_en || ram2_read_en) begin
            bank_one <= ram1_read_en;
            state    <= CAPTURE;
          end
        end
        CAPTURE: begin
          cap_reg <= bank_one ? ram1_read : ram2_read;
          state   <= SHIFT;
        end
        SHIFT: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if ((state != IDLE) && scroll_tick) begin
        pending <= 1'b1;
        if (pending) tick_miss <= 1'b1;
      end
    end
  end

  // Window shift register: newest row enters at index 0, oldest leaves at DEPTH-1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) window[i] <= '0;
    end else if (do_shift) begin
      for (int i = DEPTH - 1; i > 0; i--) window[i] <= window[i-1];
      window[0] <= cap_reg;
    end
  end

  // Fill level, saturating once the window has seen DEPTH rows.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      row_count <= '0;
    end else if (do_shift && !full) begin
      row_count <= row_count + CW'(1);
    end
  end

  // Evicted-row handoff: a loading shift beats a same-cycle accept; overwriting an unaccepted row is sticky overrun.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_row   <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (map) begin
      if (do_shift && full) begin
        out_row   <= window[DEPTH-1];
        out_valid <= 1'b1;
        if (out_valid && !out_ready) overrun <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_map_scroll_buffer.sv
// Self-checking bench for map_scroll_buffer: directed scenarios plus random
// traffic, all compared each cycle against a queue-based row model.
module tb_map_scroll_buffer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic             clk;
  logic             resetn;
  logic             map;
  logic [WIDTH-1:0] ram1_read;
  logic [WIDTH-1:0] ram2_read;
  logic             ram1_read_en;
  logic             ram2_read_en;
  logic             scroll_tick;
  logic [2:0]       rd_idx;
  logic [WIDTH-1:0] rd_row;
  logic [WIDTH-1:0] out_row;
  logic             out_valid;
  logic             out_ready;
  logic             full;
  logic             overrun;
  logic             tick_miss;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: window as a queue (front = newest), transaction progress as a step number.
  logic [WIDTH-1:0] mWin [$];
  int               mStep;
  bit               mPend;
  bit               mBankOne;
  logic [WIDTH-1:0] mCap;
  int               mCount;
  logic [WIDTH-1:0] mOrow;
  bit               mOvalid;
  bit               mOver;
  bit               mMiss;

  map_scroll_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .map(map),
    .ram1_read(ram1_read), .ram2_read(ram2_read),
    .ram1_read_en(ram1_read_en), .ram2_read_en(ram2_read_en),
    .scroll_tick(scroll_tick), .rd_idx(rd_idx), .rd_row(rd_row),
    .out_row(out_row), .out_valid(out_valid), .out_ready(out_ready),
    .full(full), .overrun(overrun), .tick_miss(tick_miss)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic modelReset();
    mWin = {};
    for (int i = 0; i < DEPTH; i++) mWin.push_back('0);
    mStep = 0; mPend = 0; mBankOne = 0; mCap = '0; mCount = 0;
    mOrow = '0; mOvalid = 0; mOver = 0; mMiss = 0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic modelStep();
    int oldStep;
    bit oldPend;
    bit oldValid;
    oldStep  = mStep;
    oldPend  = mPend;
    oldValid = mOvalid;
    if (!map) begin
      mStep = 0;
      mPend = 0;
    end else begin
      if (oldValid && out_ready) mOvalid = 0;
      if (oldStep == 0) begin
        if (scroll_tick || oldPend) begin mStep = 1; mPend = 0; end
      end else if (oldStep == 1) begin
        if (ram1_read_en || ram2_read_en) begin mBankOne = ram1_read_en; mStep = 2; end
      end else if (oldStep == 2) begin
        mCap  = mBankOne ? ram1_read : ram2_read;
        mStep = 3;
      end else begin
        if (mCount == DEPTH) begin
          mOrow   = mWin[DEPTH-1];
          mOvalid = 1;
          if (oldValid && !out_ready) mOver = 1;
        end
        mWin.push_front(mCap);
        void'(mWin.pop_back());
        if (mCount < DEPTH) mCount++;
        mStep = 0;
      end
      if (oldStep != 0 && scroll_tick) begin
        if (oldPend) mMiss = 1;
        mPend = 1;
      end
    end
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, ".out_row"},   out_row,   mOrow);
    checkOutput({tag, ".out_valid"}, out_valid, mOvalid);
    checkOutput({tag, ".full"},      full,      (mCount == DEPTH));
    checkOutput({tag, ".overrun"},   overrun,   mOver);
    checkOutput({tag, ".tick_miss"}, tick_miss, mMiss);
    checkOutput({tag, ".rd_row"},    rd_row,    mWin[rd_idx]);
  endtask

  // One clock of stimulus: drive, update model, let the edge happen, compare just after it.
  task automatic applyStimulus(input bit m, input bit t, input bit e1, input bit e2,
                               input logic [7:0] r1, input logic [7:0] r2,
                               input bit rdy, input logic [2:0] idx, input string tag);
    map = m; scroll_tick = t; ram1_read_en = e1; ram2_read_en = e2;
    ram1_read = r1; ram2_read = r2; out_ready = rdy; rd_idx = idx;
    modelStep();
    @(posedge clk);
    #1;
    compareAll(tag);
  endtask

  // Full row transaction: tick, bank strobe, data, shift.
  task automatic doRow(input logic [7:0] v, input bit useBank1, input bit rdy);
    applyStimulus(1, 1, 0, 0, 8'h00, 8'h00, rdy, 0, "row_tick");
    applyStimulus(1, 0, useBank1, !useBank1, 8'h00, 8'h00, rdy, 0, "row_strobe");
    applyStimulus(1, 0, 0, 0, useBank1 ? v : ~v, useBank1 ? ~v : v, rdy, 0, "row_data");
    applyStimulus(1, 0, 0, 0, 8'h00, 8'h00, rdy, 0, "row_shift");
  endtask

  // Asynchronous reset pulse, checked between clock edges.
  task automatic doReset(input string tag);
    scroll_tick = 0;
    #2 resetn = 1'b0;
    #1;
    modelReset();
    checkOutput({tag, ".async_out_row"},   out_row,   0);
    checkOutput({tag, ".async_out_valid"}, out_valid, 0);
    checkOutput({tag, ".async_full"},      full,      0);
    checkOutput({tag, ".async_overrun"},   overrun,   0);
    checkOutput({tag, ".async_tick_miss"}, tick_miss, 0);
    checkOutput({tag, ".async_rd_row"},    rd_row,    0);
    @(posedge clk);
    #2 resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; map = 0; scroll_tick = 0; ram1_read_en = 0; ram2_read_en = 0;
    ram1_read = '0; ram2_read = '0; out_ready = 0; rd_idx = '0;
    modelReset();
    @(posedge clk);
    #1;
    compareAll("reset");
    #2 resetn = 1'b1;

    // First row lands on rd_row four cycles after the tick.
    doRow(8'hA5, 1, 1);
    checkOutput("first_row", rd_row, 8'hA5);
    checkOutput("first_full", full, 0);
    checkOutput("first_valid", out_valid, 0);

    // Nine rows: the ninth evicts the first.
    doReset("fill");
    for (int i = 1; i <= 9; i++) doRow(8'(i), (i % 2) == 1, 1);
    checkOutput("evict_row", out_row, 8'h01);
    checkOutput("evict_valid", out_valid, 1);
    checkOutput("evict_full", full, 1);
    checkOutput("newest", rd_row, 8'h09);
    rd_idx = 3'd7;
    #1 checkOutput("oldest", rd_row, 8'h02);

    // Two more rows with the judge stalled.
    doRow(8'h0A, 1, 0);
    doRow(8'h0B, 0, 0);
    checkOutput("stall_row", out_row, 8'h03);
    checkOutput("stall_valid", out_valid, 1);
    checkOutput("stall_overrun", overrun, 1);

    // Reset while in CAPTURE aborts the row.
    applyStimulus(1, 1, 0, 0, 8'h00, 8'h00, 0, 0, "abort_tick");
    applyStimulus(1, 0, 1, 0, 8'h00, 8'h00, 0, 0, "abort_strobe");
    doReset("abort");
    ram1_read = 8'h77;
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 8'h77, 8'h77, 0, 0, "abort_after");
    checkOutput("abort_no_shift", rd_row, 8'h00);

    // Extra ticks while busy: one pended, one dropped.
    applyStimulus(1, 1, 0, 0, 8'h00, 8'h00, 1, 0, "miss_tick");
    applyStimulus(1, 1, 1, 0, 8'h00, 8'h00, 1, 0, "miss_arm");
    applyStimulus(1, 1, 0, 0, 8'h31, 8'h00, 1, 0, "miss_cap");
    applyStimulus(1, 0, 0, 0, 8'h00, 8'h00, 1, 0, "miss_shift");
    applyStimulus(1, 0, 0, 0, 8'h00, 8'h00, 1, 0, "miss_idle");
    applyStimulus(1, 0, 0, 1, 8'h00, 8'h00, 1, 0, "miss_arm2");
    applyStimulus(1, 0, 0, 0, 8'h00, 8'h32, 1, 0, "miss_cap2");
    applyStimulus(1, 0, 0, 0, 8'h00, 8'h00, 1, 0, "miss_shift2");
    checkOutput("miss_flag", tick_miss, 1);
    checkOutput("miss_row0", rd_row, 8'h32);
    rd_idx = 3'd1;
    #1 checkOutput("miss_row1", rd_row, 8'h31);

    // Both strobes pick RAM1; dropping map in CAPTURE aborts.
    doReset("bank");
    applyStimulus(1, 1, 0, 0, 8'h00, 8'h00, 1, 0, "both_tick");
    applyStimulus(1, 0, 1, 1, 8'h00, 8'h00, 1, 0, "both_strobe");
    applyStimulus(1, 0, 0, 0, 8'h11, 8'h22, 1, 0, "both_data");
    applyStimulus(1, 0, 0, 0, 8'h00, 8'h00, 1, 0, "both_shift");
    checkOutput("both_ram1", rd_row, 8'h11);
    applyStimulus(1, 1, 0, 0, 8'h00, 8'h00, 1, 0, "drop_tick");
    applyStimulus(1, 0, 0, 1, 8'h00, 8'h00, 1, 0, "drop_strobe");
    applyStimulus(0, 0, 0, 0, 8'h55, 8'h55, 1, 0, "drop_map");
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 8'h55, 8'h55, 1, 0, "drop_after");
    checkOutput("drop_window", rd_row, 8'h11);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      applyStimulus(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                    8'($urandom), 8'($urandom), ($urandom_range(0, 1) == 1),
                    3'($urandom_range(0, 7)), "rand");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/map_scroll_buffer.md
MAP_SCROLL_BUFFER -- requirements
Module: map_scroll_buffer

Interface
REQ-001 SHALL have parameter WIDTH, 8, bit width of one map row (one bit per note lane).
REQ-002 SHALL have parameter DEPTH, 8, number of rows held in the scroll window (power of two).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port map  input  1  map-mode enable, same signal that gates the RAM ping-pong controller.
REQ-006 SHALL have port ram1_read  input  WIDTH  RAM1 read data, valid one cycle after ram1_read_en.
REQ-007 SHALL have port ram2_read  input  WIDTH  RAM2 read data, valid one cycle after ram2_read_en.
REQ-008 SHALL have port ram1_read_en  input  1  RAM1 read strobe from the ping-pong controller.
REQ-009 SHALL have port ram2_read_en  input  1  RAM2 read strobe from the ping-pong controller.
REQ-010 SHALL have port scroll_tick  input  1  one-cycle pulse requesting a one-row scroll.
REQ-011 SHALL have port rd_idx  input  log2(DEPTH)  renderer row select; 0 = newest row.
REQ-012 SHALL have port rd_row  output  WIDTH  combinational window[rd_idx].
REQ-013 SHALL have port out_row  output  WIDTH  row leaving the window (to hit judge).
REQ-014 SHALL have port out_valid  output  1  out_row valid; held until accepted.
REQ-015 SHALL have port out_ready  input  1  hit judge accepts out_row when out_valid&&out_ready.
REQ-016 SHALL have port full  output  1  window holds DEPTH captured rows.
REQ-017 SHALL have port overrun  output  1  sticky: unaccepted out_row overwritten.
REQ-018 SHALL have port tick_miss  output  1  sticky: scroll_tick dropped.

Function
REQ-019 SHALL implement FSM states IDLE, ARM, CAPTURE, SHIFT.
REQ-020 IDLE: map && (scroll_tick || pending) -> ARM, clearing pending.
REQ-021 ARM: ram1_read_en or ram2_read_en high -> latch bank (1 if ram1_read_en, else 2; ram1 wins if both) -> CAPTURE; neither high -> stay.
REQ-022 CAPTURE: cap_reg <= ram1_read or ram2_read per latched bank -> SHIFT.
REQ-023 SHIFT: window[i] <= window[i-1] for i=DEPTH-1..1, window[0] <= cap_reg; -> IDLE.
REQ-024 SHIFT SHALL increment row_count, saturating at DEPTH; full = (row_count == DEPTH).
REQ-025 SHIFT with full already 1 SHALL load out_row <= old window[DEPTH-1] and set out_valid; with full 0 SHALL leave out_row/out_valid unchanged.
REQ-026 out_valid SHALL clear on out_valid && out_ready unless a loading SHIFT occurs in the same cycle, in which case it stays 1 with the new row.
REQ-027 Loading SHIFT while out_valid=1 and out_ready=0 SHALL overwrite out_row and set overrun.
REQ-028 scroll_tick outside IDLE SHALL set pending; if pending already 1, tick_miss SHALL set.
REQ-029 Latency: tick in IDLE at cycle T with read strobe at T+1 -> new row visible on rd_row at T+4.
REQ-030 map low SHALL force FSM to IDLE at next edge, clear pending, hold window, row_count, out_row, out_valid, flags.
REQ-031 rd_row SHALL be purely combinational from window and rd_idx.

Reset
REQ-032 resetn low SHALL immediately force: FSM IDLE, window all 0, cap_reg 0, row_count 0, pending 0, out_row 0, out_valid 0, full 0, overrun 0, tick_miss 0.
REQ-033 Reset mid-operation (ARM/CAPTURE/SHIFT) SHALL abort with no window update after release.
REQ-034 Sticky flags SHALL clear only by reset.

Verification
REQ-035 map=1, strobes alternate, ram1_read=8'hA5 after ram1 strobe, tick at T with ram1_read_en at T+1 -> rd_idx=0 gives 8'hA5 at T+4, full=0, out_valid=0.
REQ-036 Nine ticks capturing 8'h01..8'h09, out_ready=1 -> after ninth SHIFT out_row=8'h01 with out_valid pulse, full=1, window[0]=8'h09, window[7]=8'h02.
REQ-037 Window full, out_ready=0, two further ticks -> out_valid stays 1, out_row = second evicted row, overrun=1.
REQ-038 Tick, then two more ticks while in ARM/CAPTURE -> pending serviced (two SHIFTs total), tick_miss=1.
REQ-039 Both strobes high in ARM -> ram1_read captured; map dropped in CAPTURE -> IDLE next edge, window unchanged.
REQ-040 resetn pulsed low in CAPTURE -> all outputs 0 asynchronously, no SHIFT after release.
